// File: rtl/regfile_dump.sv
// Debug read-out engine: walks a register range through one RF read port and streams (index, value) words.
// Latency: 2 cycles per word with ready held high; backpressure holds the current word stable in SEND.
module regfile_dump #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         dump_start,
    input  logic [4:0]   first_reg,
    input  logic [4:0]   last_reg,
    input  logic         dump_abort,
    output logic [4:0]   rf_read_reg,
    input  logic [N-1:0] rf_read_data,
    output logic         stall_req,
    output logic         dump_valid,
    input  logic         dump_ready,
    output logic [N-1:0] dump_data,
    output logic [4:0]   dump_index,
    output logic         dump_last,
    output logic         busy,
    output logic         done,
    output logic         dump_err,
    output logic [N-1:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] idx;
    logic [4:0] last_q;
    logic       start_ok;
    logic       start_bad;
    logic       hshake;

    assign start_ok  = (state == S_IDLE) && dump_start && (first_reg <= last_reg);
    assign start_bad = (state == S_IDLE) && dump_start && (first_reg > last_reg);
    assign hshake    = (state == S_SEND) && dump_ready;

    assign rf_read_reg = idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_ok) state_nxt = S_READ;
            S_READ: state_nxt = S_SEND;
            S_SEND: if (hshake) state_nxt = dump_last ? S_DONE : S_READ;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Abort wins over every transition; a word accepted on the same edge is still counted below.
        if (dump_abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        stall_req  = 1'b0;
        dump_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_READ: begin
                stall_req = 1'b1;
                busy      = 1'b1;
            end
            S_SEND: begin
                stall_req  = 1'b1;
                dump_valid = 1'b1;
                busy       = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            last_q     <= '0;
            dump_data  <= '0;
            dump_index <= '0;
            dump_last  <= 1'b0;
            dump_err   <= 1'b0;
            checksum   <= '0;
        end else begin
            dump_err <= start_bad;
            if (start_ok) begin
                idx      <= first_reg;
                last_q   <= last_reg;
                checksum <= '0;
            end
            if (state == S_READ) begin
                dump_data  <= rf_read_data;
                dump_index <= idx;
                dump_last  <= (idx == last_q);
            end
            if (hshake) begin
                checksum <= checksum + dump_data;
                // idx < last_q <= 31 here, so the increment cannot wrap.
                if (!dump_last) begin
                    idx <= idx + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: RF model reg[i] = i*3, handshake monitor and hand-computed expectations.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        dump_start;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic        dump_abort;
    logic [4:0]  rf_read_reg;
    logic [31:0] rf_read_data;
    logic        stall_req;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [4:0]  dump_index;
    logic        dump_last;
    logic        busy;
    logic        done;
    logic        dump_err;
    logic [31:0] checksum;

    logic [31:0] rf [32];
    assign rf_read_data = rf[rf_read_reg];

    always #5 clk = ~clk;

    regfile_dump #(.N(32)) dut (
        .clk(clk), .reset(reset), .dump_start(dump_start), .first_reg(first_reg),
        .last_reg(last_reg), .dump_abort(dump_abort), .rf_read_reg(rf_read_reg),
        .rf_read_data(rf_read_data), .stall_req(stall_req), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_data(dump_data), .dump_index(dump_index),
        .dump_last(dump_last), .busy(busy), .done(done), .dump_err(dump_err),
        .checksum(checksum)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshake / pulse monitor, sampled mid-cycle.
    logic [31:0] hs_idx [$];
    logic [31:0] hs_dat [$];
    logic [31:0] hs_last [$];
    int          done_cnt;
    int          stall_cnt;
    int          err_cnt;
    logic        pv, pr, pl;
    logic [31:0] pd;
    logic [4:0]  pi;

    always @(negedge clk) begin
        if (reset) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr && dump_valid) begin
                check("hold_data", dump_data, pd);
                check("hold_index", 32'(dump_index), 32'(pi));
                check("hold_last", 32'(dump_last), 32'(pl));
            end
            if (dump_valid && dump_ready) begin
                hs_idx.push_back(32'(dump_index));
                hs_dat.push_back(dump_data);
                hs_last.push_back(32'(dump_last));
            end
            if (done)      done_cnt++;
            if (stall_req) stall_cnt++;
            if (dump_err)  err_cnt++;
            pv = dump_valid;
            pr = dump_ready;
            pd = dump_data;
            pi = dump_index;
            pl = dump_last;
        end
    end

    int ph = 0;
    int rmode = 0;   // 0: ready high, 1: one cycle on / two off, 2: ready low

    task automatic tick();
        @(posedge clk);
        #1;
        ph++;
        case (rmode)
            0:       dump_ready = 1'b1;
            1:       dump_ready = (ph % 3 == 0);
            default: dump_ready = 1'b0;
        endcase
    endtask

    task automatic clear_mon();
        hs_idx.delete();
        hs_dat.delete();
        hs_last.delete();
        done_cnt  = 0;
        stall_cnt = 0;
        err_cnt   = 0;
    endtask

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        dump_start = 1'b1;
        first_reg  = f;
        last_reg   = l;
        tick();
        dump_start = 1'b0;
    endtask

    // Cycle 1 is the cycle that carries dump_start; returns the cycle in which done was seen.
    task automatic wait_idle(input int budget, output int done_cyc);
        done_cyc = 0;
        for (int c = 2; c < budget; c++) begin
            if (done) done_cyc = c;
            if (!busy) return;
            tick();
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_word(input logic [4:0] index);
        for (int c = 0; c < 40; c++) begin
            if (dump_valid && dump_index == index) return;
            tick();
        end
        check("word_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rf_read_reg"}, 32'(rf_read_reg), 32'd0);
        check({tag, "_stall_req"},   32'(stall_req),   32'd0);
        check({tag, "_dump_valid"},  32'(dump_valid),  32'd0);
        check({tag, "_dump_data"},   dump_data,        32'd0);
        check({tag, "_dump_index"},  32'(dump_index),  32'd0);
        check({tag, "_dump_last"},   32'(dump_last),   32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_done"},        32'(done),        32'd0);
        check({tag, "_dump_err"},    32'(dump_err),    32'd0);
        check({tag, "_checksum"},    checksum,         32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
        reset      = 1'b0;
        dump_start = 1'b0;
        dump_abort = 1'b0;
        dump_ready = 1'b1;
        first_reg  = '0;
        last_reg   = '0;
        clear_mon();
        #2 reset = 1'b1;
        #2;
        check_reset_outputs("reset");
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Full dump 0..31 with ready held high.
        rmode = 0;
        clear_mon();
        start_dump(5'd0, 5'd31);
        wait_idle(200, dc);
        check("full_done_cycle", 32'(dc), 32'd66);
        check("full_count", 32'(hs_idx.size()), 32'd32);
        for (int i = 0; i < 32 && i < hs_idx.size(); i++) begin
            check($sformatf("full_idx%0d", i),  hs_idx[i],  32'(i));
            check($sformatf("full_dat%0d", i),  hs_dat[i],  32'(i * 3));
            check($sformatf("full_last%0d", i), hs_last[i], (i == 31) ? 32'd1 : 32'd0);
        end
        check("full_checksum", checksum, 32'h5D0);
        check("full_stall_cycles", 32'(stall_cnt), 32'd64);
        check("full_done_pulses", 32'(done_cnt), 32'd1);

        // Range 5..7 under 1-on/2-off backpressure.
        rmode = 1;
        clear_mon();
        start_dump(5'd5, 5'd7);
        wait_idle(200, dc);
        check("bp_count", 32'(hs_idx.size()), 32'd3);
        for (int i = 0; i < 3 && i < hs_idx.size(); i++) begin
            check($sformatf("bp_idx%0d", i),  hs_idx[i],  32'(5 + i));
            check($sformatf("bp_dat%0d", i),  hs_dat[i],  32'((5 + i) * 3));
            check($sformatf("bp_last%0d", i), hs_last[i], (i == 2) ? 32'd1 : 32'd0);
        end
        check("bp_checksum", checksum, 32'd54);
        check("bp_done_pulses", 32'(done_cnt), 32'd1);

        // Rejected start (first > last).
        rmode = 0;
        clear_mon();
        dump_start = 1'b1;
        first_reg  = 5'd9;
        last_reg   = 5'd3;
        tick();
        dump_start = 1'b0;
        check("rej_err_pulse", 32'(dump_err), 32'd1);
        check("rej_busy", 32'(busy), 32'd0);
        tick();
        check("rej_err_clear", 32'(dump_err), 32'd0);
        check("rej_busy2", 32'(busy), 32'd0);
        check("rej_checksum", checksum, 32'd54);
        check("rej_err_count", 32'(err_cnt), 32'd1);

        // Abort while the second word waits with ready low.
        clear_mon();
        start_dump(5'd0, 5'd31);
        wait_word(5'd1);
        rmode      = 2;
        dump_ready = 1'b0;
        dump_abort = 1'b1;
        tick();
        dump_abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(dump_valid), 32'd0);
        check("abort_stall", 32'(stall_req), 32'd0);
        check("abort_checksum", checksum, 32'd0);
        check("abort_count", 32'(hs_idx.size()), 32'd1);
        tick();
        check("abort_done_pulses", 32'(done_cnt), 32'd0);

        rmode = 0;
        clear_mon();
        start_dump(5'd3, 5'd4);
        wait_idle(100, dc);
        check("after_abort_checksum", checksum, 32'd21);
        check("after_abort_count", 32'(hs_idx.size()), 32'd2);
        check("after_abort_done", 32'(done_cnt), 32'd1);

        // Abort coinciding with a handshake: the word still counts.
        clear_mon();
        start_dump(5'd2, 5'd4);
        wait_word(5'd3);
        dump_abort = 1'b1;
        tick();
        dump_abort = 1'b0;
        check("abort_hs_checksum", checksum, 32'd15);
        check("abort_hs_busy", 32'(busy), 32'd0);
        check("abort_hs_count", 32'(hs_idx.size()), 32'd2);
        tick();
        check("abort_hs_done", 32'(done_cnt), 32'd0);

        // Asynchronous reset between edges, mid-dump.
        clear_mon();
        start_dump(5'd0, 5'd31);
        for (int i = 0; i < 5; i++) tick();
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("async");
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Second start while busy is ignored.
        clear_mon();
        start_dump(5'd10, 5'd12);
        tick();
        dump_start = 1'b1;
        first_reg  = 5'd0;
        last_reg   = 5'd31;
        tick();
        dump_start = 1'b0;
        wait_idle(100, dc);
        check("busy_start_count", 32'(hs_idx.size()), 32'd3);
        for (int i = 0; i < 3 && i < hs_idx.size(); i++) begin
            check($sformatf("busy_start_idx%0d", i), hs_idx[i], 32'(10 + i));
        end
        check("busy_start_checksum", checksum, 32'd99);
        check("busy_start_done", 32'(done_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the RV32 integer register file. On request it walks a range of architectural registers through one register-file read port and streams each value out over a valid/ready interface, tagged with the register index. It asserts a stall request while it walks, so the pipeline does not write registers during the dump, and it reports a checksum at completion. It sits beside the register file, sharing a read-address mux with the decode stage, and feeds a debug/UART transmitter.

## Interface
- N, 32, data width of register-file entries and of the stream.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- dump_start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- first_reg  in  5  first index to dump; sampled with dump_start.
- last_reg  in  5  last index to dump, inclusive; sampled with dump_start.
- dump_abort  in  1  synchronous abort; highest priority after reset.
- rf_read_reg  out  5  read address to the register file (combinational read).
- rf_read_data  in  N  read data returned by the register file.
- stall_req  out  1  high while a dump is in progress; the pipeline must block RegWrite.
- dump_valid  out  1  stream word is valid.
- dump_ready  in  1  downstream accepts the word.
- dump_data  out  N  register value.
- dump_index  out  5  register index of dump_data.
- dump_last  out  1  high with the final word of the range.
- busy  out  1  the state machine is not in IDLE.
- done  out  1  one-cycle pulse when the last word is accepted.
- dump_err  out  1  one-cycle pulse when a start request is rejected.
- checksum  out  N  sum mod 2^N of all words accepted in the current dump.

## Operation
- States: IDLE, READ, SEND, DONE.
- **IDLE**
  - dump_start with first_reg <= last_reg: latch first_reg and last_reg, set idx = first_reg, clear checksum, go to READ.
  - dump_start with first_reg > last_reg: pulse dump_err for one cycle and stay in IDLE. checksum is unchanged.
- **READ**
  - rf_read_reg = idx.
  - At the clock edge, capture rf_read_data into dump_data and idx into dump_index. Set dump_last = (idx == last).
  - Go to SEND.
- **SEND**
  - dump_valid = 1. dump_data, dump_index and dump_last are held stable until the handshake.
  - On the handshake (dump_valid & dump_ready), checksum += dump_data, truncated to N bits.
  - After the handshake: if dump_last, go to DONE; otherwise idx = idx + 1 and go to READ.
- **DONE**
  - done = 1 for exactly one cycle, then go to IDLE.
  - checksum holds its final value until the next accepted start.
- rf_read_reg = idx in every state. The address is valid only in READ; a value of idx in other states is don't-care to the register file.
- Register 0 is dumped like any other register; the register file returns 0 for it.
- stall_req = 1 in READ and SEND, and 0 in IDLE and DONE.
- busy = 1 in READ, SEND and DONE.
- dump_start is ignored in any state other than IDLE.
- dump_abort in READ, SEND or DONE:
  - Go to IDLE at the next edge. dump_valid drops at that edge.
  - done does not pulse, and checksum keeps its partial value.
  - dump_abort in IDLE has no effect.
- Simultaneous dump_abort and handshake in SEND: the word counts as accepted and is added to checksum, then the block goes to IDLE with no done pulse.
- idx never wraps, because last_reg <= 31 and the range is checked at start. A single-register range (first_reg == last_reg) is legal.

## Timing
- Reset values: state IDLE; rf_read_reg 0; stall_req 0; dump_valid 0; dump_data 0; dump_index 0; dump_last 0; busy 0; done 0; dump_err 0; checksum 0.
- Reset asserted mid-dump clears everything immediately (asynchronously). No done pulse.
- From dump_start (edge k) to READ at k+1, with dump_valid first high at k+2.
- With dump_ready held high, each word takes 2 cycles, so a 32-register dump takes 64 cycles from the first READ to the final handshake. done pulses in the cycle after the final handshake.
- All outputs are registered or decoded from state only; no input-to-output combinational path.
- dump_err pulses in the cycle after the rejected dump_start.

## Test plan
- Full dump with dump_ready = 1 and reg[i] = i*3 for i >= 1:
  - 32 words, indices 0..31 in order, with dump_data = i*3 (0 for index 0).
  - dump_last only on index 31; done at cycle 66 after start.
  - checksum = 0x5D0; stall_req is high for exactly 64 cycles.
- Range 5..7 with dump_ready toggling 1 cycle on, 2 cycles off:
  - Outputs stay stable while ready is low; exactly 3 handshakes, with indices 5, 6, 7.
- Start with first_reg = 9, last_reg = 3:
  - dump_err pulses once; busy stays 0; checksum is unchanged.
- dump_abort during SEND of the second word of range 0..31:
  - Back to IDLE next cycle; no done pulse; checksum = reg[0] only.
  - A subsequent start works normally.
- Async reset asserted mid-dump (between clock edges):
  - All outputs are at reset values before the next edge.
- dump_start pulsed again while busy:
  - Ignored; the dump completes with its original range.
